instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, meaning memory address of the first word written.
REQ-002 SHALL have parameter DEPTH, default 256, meaning maximum words per load session, equal to the instruction memory size.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load session.
REQ-006 SHALL have port word_count  input  9  number of 16-bit words to load, sampled on accepted start.
REQ-007 SHALL have port byte_in  input  8  incoming program byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-009 SHALL have port byte_ready  output  1  loader can accept a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  instruction memory write strobe.
REQ-011 SHALL have port mem_address  output  16  instruction memory word address.
REQ-012 SHALL have port mem_data  output  16  instruction word to write.
REQ-013 SHALL have port busy  output  1  session in progress; drives CPU halt.
REQ-014 SHALL have port done  output  1  sticky flag: last session completed.
REQ-015 SHALL have port error  output  1  sticky flag: last start rejected.

Function
REQ-016 SHALL implement states IDLE, GET_HI, GET_LO, WRITE.
REQ-017 In IDLE, start with word_count in 1..DEPTH SHALL clear done/error, zero word index, latch word_count, and go to GET_HI.
REQ-018 In IDLE, start with word_count = 0 SHALL set done next cycle, clear error, and write nothing.
REQ-019 In IDLE, start with word_count > DEPTH SHALL set error next cycle, clear done, and write nothing.
REQ-020 Start while busy SHALL be ignored.
REQ-021 byte_ready SHALL be 1 exactly in GET_HI and GET_LO; a byte is accepted only when byte_valid and byte_ready are both 1.
REQ-022 An accepted byte in GET_HI SHALL be latched as the upper byte (big-endian), then go to GET_LO.
REQ-023 An accepted byte in GET_LO SHALL be latched as the lower byte, then go to WRITE.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle with mem_address = BASE_ADDR + index (16-bit, wraps modulo 2^16) and mem_data = {hi, lo}.
REQ-025 After WRITE, index SHALL increment; if the new index equals the latched count, go to IDLE and set done, else go to GET_HI.
REQ-026 Minimum throughput SHALL be one word per 3 cycles; byte_valid gaps SHALL stall the FSM with no state or output change.
REQ-027 busy SHALL be 1 in GET_HI, GET_LO and WRITE, else 0.
REQ-028 mem_we SHALL be 0 in every state other than WRITE; mem_address/mem_data are don't-care when mem_we = 0.
REQ-029 Bytes presented while byte_ready = 0 SHALL be ignored and not consumed.

Reset
REQ-030 rst SHALL return the FSM to IDLE on the next edge regardless of state, with priority over start and byte handshakes.
REQ-031 After reset: busy=0, byte_ready=0, mem_we=0, done=0, error=0, index=0, mem_address=BASE_ADDR, mem_data=0.
REQ-032 Reset mid-session SHALL discard any partial word; words already written remain in memory; no further write occurs.

Verification
REQ-033 start, word_count=2, bytes 69,08,6B,04 back-to-back -> writes (0000,6908) and (0001,6B04), one mem_we each; done=1, busy=0 after second write.
REQ-034 Same load with byte_valid low 2 cycles between every byte -> identical writes; byte_ready stays high while waiting; no extra mem_we.
REQ-035 start, word_count=0 -> done=1 next cycle, error=0, mem_we never asserted; start, word_count=300 -> error=1, done=0, no writes.
REQ-036 word_count=256 with bytes 00..FF repeating -> 256 writes, addresses 0000..00FF, last data FEFF; done=1.
REQ-037 rst asserted after high byte 12 of word 1 (word 0 = ABCD written) -> IDLE next cycle, all outputs at reset values, no write of word 1.
REQ-038 start pulsed during busy with word_count=5 -> ignored; original count 2 completes with exactly 2 writes.

Source files
------------

// File: rtl/instruction_loader.sv
// Byte-serial program loader: assembles big-endian byte pairs into 16-bit
// instruction words and writes them to sequential instruction memory addresses.
module instruction_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          DEPTH     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_HI = 2'd1,
        GET_LO = 2'd2,
        WRITE  = 2'd3
    } state_t;

    localparam logic [9:0] DEPTH_W = 10'(DEPTH);

    state_t      r_state;
    state_t      w_state_next;
    logic [8:0]  r_index;
    logic [8:0]  r_count;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_done;
    logic        r_error;

    logic        w_accept;
    logic        w_count_zero;
    logic        w_count_over;
    logic        w_start_ok;
    logic [8:0]  w_index_inc;
    logic        w_last_word;

    assign w_accept     = byte_valid & byte_ready;
    assign w_count_zero = (word_count == 9'd0);
    assign w_count_over = ({1'b0, word_count} > DEPTH_W);
    assign w_start_ok   = start & ~w_count_zero & ~w_count_over;
    assign w_index_inc  = r_index + 9'd1;
    assign w_last_word  = (w_index_inc == r_count);

    // Next-state and per-state outputs.
    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        busy         = 1'b0;
        mem_we       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_state_next = GET_HI;
                end
            end
            GET_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) begin
                    w_state_next = GET_LO;
                end
            end
            GET_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept) begin
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                busy         = 1'b1;
                mem_we       = 1'b1;
                w_state_next = w_last_word ? IDLE : GET_HI;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_index <= 9'd0;
            r_count <= 9'd0;
            r_hi    <= 8'd0;
            r_lo    <= 8'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    // Rejected and empty sessions resolve here without leaving IDLE.
                    if (start) begin
                        if (w_count_zero) begin
                            r_done  <= 1'b1;
                            r_error <= 1'b0;
                        end else if (w_count_over) begin
                            r_done  <= 1'b0;
                            r_error <= 1'b1;
                        end else begin
                            r_done  <= 1'b0;
                            r_error <= 1'b0;
                            r_index <= 9'd0;
                            r_count <= word_count;
                        end
                    end
                end
                GET_HI: begin
                    if (w_accept) begin
                        r_hi <= byte_in;
                    end
                end
                GET_LO: begin
                    if (w_accept) begin
                        r_lo <= byte_in;
                    end
                end
                WRITE: begin
                    r_index <= w_index_inc;
                    if (w_last_word) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address arithmetic is 16-bit, so sessions near the top of memory wrap.
    assign mem_address = BASE_ADDR + {7'd0, r_index};
    assign mem_data    = {r_hi, r_lo};
    assign done        = r_done;
    assign error       = r_error;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed sessions plus randomized
// sessions compared against an expected-write queue built from the byte stream.
module tb_instruction_loader;

    localparam logic [15:0] BASE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    instruction_loader #(
        .BASE_ADDR (BASE),
        .DEPTH     (256)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word_count  (word_count),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_writes;
    logic [15:0] last_wr_data;
    logic [15:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [7:0]  bytes_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; any write seen is matched against the expected-write queue.
    task automatic step();
        @(posedge clk);
        #1;
        if (mem_we === 1'b1) begin
            n_writes++;
            last_wr_data = mem_data;
            $display("[TB] write addr=%h data=%h", mem_address, mem_data);
            n_tests++;
            assert (exp_addr_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                       mem_address, mem_data);
            end
            if (exp_addr_q.size() != 0) begin
                check("wr_addr", {16'd0, mem_address}, {16'd0, exp_addr_q.pop_front()});
                check("wr_data", {16'd0, mem_data}, {16'd0, exp_data_q.pop_front()});
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted;
        bit rdy;
        byte_valid = 1'b0;
        repeat (gap) step();
        if (gap > 0) check("ready_wait", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b1;
        byte_in    = b;
        accepted   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            rdy = byte_ready;
            step();
            if (rdy) begin
                accepted = 1'b1;
                break;
            end
        end
        n_tests++;
        assert (accepted) else begin
            n_fail++;
            $error("FAIL accept_timeout: observed no handshake expected byte %h taken", b);
        end
        byte_valid = 1'b0;
    endtask

    // Full session from bytes_q; inject_at >= 0 pulses a rejected start mid-session.
    task automatic load(input int n, input int gapmin, input int gapmax, input int inject_at);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(BASE + 16'(i));
            exp_data_q.push_back({bytes_q[2*i], bytes_q[2*i+1]});
        end
        n_writes   = 0;
        start      = 1'b1;
        word_count = 9'(n);
        byte_valid = 1'b1;
        byte_in    = 8'hEE;
        step();
        start      = 1'b0;
        byte_valid = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_done_clr", {31'd0, done}, 32'd0);
        check("start_err_clr", {31'd0, error}, 32'd0);
        for (int k = 0; k < 2*n; k++) begin
            if (k == inject_at) begin
                start      = 1'b1;
                word_count = 9'd5;
                step();
                start      = 1'b0;
            end
            send_byte(bytes_q[k], int'($urandom_range(gapmax, gapmin)));
        end
        step();
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_done", {31'd0, done}, 32'd1);
        check("end_error", {31'd0, error}, 32'd0);
        check("end_writes", n_writes, n);
        check("end_queue", exp_addr_q.size(), 0);
        $display("[TB] session words=%0d writes=%0d done=%b", n, n_writes, done);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = 9'd0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        n_writes   = 0;
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_addr", {16'd0, mem_address}, {16'd0, BASE});
        check("rst_data", {16'd0, mem_data}, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back bytes.
        bytes_q = '{8'h69, 8'h08, 8'h6B, 8'h04};
        load(2, 0, 0, -1);

        // Two idle cycles before every byte.
        bytes_q = '{8'h69, 8'h08, 8'h6B, 8'h04};
        load(2, 2, 2, -1);

        // Empty session: done without writes.
        start = 1'b1; word_count = 9'd0; step(); start = 1'b0;
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_error", {31'd0, error}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();

        // Oversized session: rejected.
        n_writes = 0;
        start = 1'b1; word_count = 9'd300; step(); start = 1'b0;
        check("over_error", {31'd0, error}, 32'd1);
        check("over_done", {31'd0, done}, 32'd0);
        check("over_busy", {31'd0, busy}, 32'd0);
        repeat (3) step();
        check("over_writes", n_writes, 0);

        // Start while busy is ignored.
        bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(2, 0, 1, 1);

        // Full-depth session.
        bytes_q.delete();
        for (int k = 0; k < 512; k++) bytes_q.push_back(8'(k));
        load(256, 0, 0, -1);
        check("full_last_data", {16'd0, last_wr_data}, 32'h0000FEFF);

        // Reset mid-session after the high byte of word 1.
        bytes_q = '{8'hAB, 8'hCD, 8'h12, 8'h34};
        exp_addr_q.push_back(BASE);
        exp_data_q.push_back(16'hABCD);
        n_writes = 0;
        start = 1'b1; word_count = 9'd2; step(); start = 1'b0;
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        send_byte(8'h12, 0);
        rst = 1'b1; byte_valid = 1'b1; byte_in = 8'h34; start = 1'b1;
        step();
        rst = 1'b0; start = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_error", {31'd0, error}, 32'd0);
        check("mid_rst_addr", {16'd0, mem_address}, {16'd0, BASE});
        check("mid_rst_data", {16'd0, mem_data}, 32'd0);
        repeat (3) step();
        byte_valid = 1'b0;
        check("mid_rst_busy2", {31'd0, busy}, 32'd0);
        check("mid_rst_writes", n_writes, 1);
        $display("[TB] reset mid-session writes=%0d", n_writes);

        // Randomized sessions.
        for (int s = 0; s < 6; s++) begin
            int n;
            n = int'($urandom_range(8, 1));
            bytes_q.delete();
            for (int k = 0; k < 2*n; k++) bytes_q.push_back(8'($urandom));
            load(n, 0, 3, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
